seg7_scan_driver: RTL and testbench
===================================

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have one clock and one reset: reset is asynchronous and active-high.
REQ-002 SHALL have parameter REFRESH_DIV, default 50000, which is the number of clk cycles per digit slot (1 kHz digit rate at 50 MHz).
REQ-003 SHALL have port clk, input, 1 bit: system clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-005 SHALL have port Y, input, 12 bits: three-digit BCD value {hundreds, tens, units}, as produced by the upstream BCD stage.
REQ-006 SHALL have port load, input, 1 bit: when high in a cycle, Y is captured.
REQ-007 SHALL have port an, output, 4 bits: digit enables, active-low; an[0] is the rightmost digit.
REQ-008 SHALL have port seg, output, 7 bits: segments {g,f,e,d,c,b,a}, active-low.
REQ-009 SHALL have port dp, output, 1 bit: decimal point, active-low, held at 1.

Function
REQ-010 SHALL capture Y into a shadow register on every clk edge where load=1; if load is asserted back-to-back, the last value wins.
REQ-011 SHALL run a prescaler counting 0..REFRESH_DIV-1 that wraps to 0 and asserts an internal tick for one cycle at REFRESH_DIV-1.
REQ-012 SHALL advance a 2-bit digit index on each tick in the order 0,1,2,3,0 (wrap from 3 to 0).
REQ-013 SHALL copy the shadow register into the display register on the tick that wraps the index to 0, so that a frame never mixes two values.
REQ-014 SHALL register an, seg and dp, which update on the clk edge after the tick (1-cycle latency from tick to outputs).
REQ-015 SHALL drive exactly one an bit low per slot: index 0 gives an=1110 (units), index 1 gives 1101 (tens), index 2 gives 1011 (hundreds), index 3 gives 0111 (unit symbol).
REQ-016 SHALL use these seg codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-017 SHALL display any nibble greater than 9 as '-' (seg=0111111).
REQ-018 SHALL perform leading-zero blanking: hundreds=0 shows blank (seg=1111111); tens=0 is blank only when hundreds is also blanked; units is never blanked.
REQ-019 SHALL treat an invalid hundreds nibble (greater than 9) as non-zero for blanking purposes.
REQ-020 SHALL, when load and the frame-transfer tick coincide, transfer the pre-load shadow value; the new value appears in the following frame.

Reset
REQ-021 SHALL, while rst=1, asynchronously force an=1111, seg=1111111, dp=1, the prescaler to 0, the index to 0, and the shadow and display registers to 0.
REQ-022 SHALL, when rst is asserted mid-frame, abort the frame with no glitch pulse on an after release.
REQ-023 SHALL, after rst is released, count from 0; the first tick occurs REFRESH_DIV cycles later.

Configuration
REQ-024 SHALL, when macro SEG7_UNIT_EN is defined, show the Celsius symbol 'C' (seg=1000110) in slot 3.
REQ-025 SHALL, when SEG7_UNIT_EN is not defined, show blank (seg=1111111) in slot 3 with an[3] still scanned; slot timing is identical in both builds.

Verification
REQ-026 SHALL include scenario 1, with REFRESH_DIV=4: assert rst, then release -> an=1111, seg=1111111, dp=1 until the first tick; first an=1110 appears 5 cycles after release.
REQ-027 SHALL include scenario 2: load Y=0x035 and run 2 frames -> units slot seg=0010010, tens slot seg=0110000, hundreds slot blank, slot 3 =1000110 (macro defined) or 1111111 (undefined).
REQ-028 SHALL include scenario 3: load Y=0x005 -> hundreds and tens blank, units seg=0010010; then load Y=0x100 -> hundreds 1111001, tens 1000000, units 1000000.
REQ-029 SHALL include scenario 4: load Y=0x0A7 -> tens slot shows '-' (0111111), units shows 1111000; load Y=0xC05 -> tens 1000000 (not blanked).
REQ-030 SHALL include scenario 5: load Y=0x012 mid-frame, then Y=0x099 in the same frame -> the current frame shows the old value unchanged and the next frame shows 99; load pulsed on the wrap tick -> the value appears one frame later.
REQ-031 SHALL include scenario 6: assert rst during slot 2 -> outputs go to reset values asynchronously, before the next clk edge; after release the scan restarts at slot 0 with the display value 0 shown as units '0' only.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Multiplexed 4-digit 7-segment scanner for a 3-digit BCD value plus a unit slot.
// Define SEG7_UNIT_EN to show a Celsius 'C' in slot 3; otherwise that slot is blank.
module seg7_scan_driver #(
   parameter int REFRESH_DIV = 50000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] Y,
   input  logic        load,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp
);

   localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
`ifdef SEG7_UNIT_EN
   localparam logic [6:0] SEG_UNIT  = 7'b1000110;
`else
   localparam logic [6:0] SEG_UNIT  = SEG_BLANK;
`endif

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       idx_q, idx_d;
   logic [1:0]       slot_q, slot_d;
   logic             upd_q, upd_d;
   logic [11:0]      shadow_q, shadow_d;
   logic [11:0]      disp_q, disp_d;
   logic [3:0]       an_q, an_d;
   logic [6:0]       seg_q, seg_d;
   logic             dp_q, dp_d;

   logic             tick;
   logic [3:0]       hund, tens, units;
   logic             hund_blank, tens_blank;
   logic [6:0]       slot_seg;

   function automatic logic [6:0] digit_to_seg(input logic [3:0] digit);
      case (digit)
         4'd0:    return 7'b1000000;
         4'd1:    return 7'b1111001;
         4'd2:    return 7'b0100100;
         4'd3:    return 7'b0110000;
         4'd4:    return 7'b0011001;
         4'd5:    return 7'b0010010;
         4'd6:    return 7'b0000010;
         4'd7:    return 7'b1111000;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0010000;
         default: return SEG_DASH;
      endcase
   endfunction

   assign tick = (cnt_q == CNT_MAX);

   // Prescaler, slot index and the shadow/display pair; the display only changes
   // on the wrap tick so one frame always shows a single captured value.
   always_comb begin
      cnt_d    = tick ? '0 : cnt_q + CNT_W'(1);
      idx_d    = tick ? idx_q + 2'd1 : idx_q;
      slot_d   = tick ? idx_q : slot_q;
      upd_d    = tick;
      shadow_d = load ? Y : shadow_q;
      disp_d   = (tick && (idx_q == 2'd3)) ? shadow_q : disp_q;
   end

   always_comb begin
      hund       = disp_q[11:8];
      tens       = disp_q[7:4];
      units      = disp_q[3:0];
      hund_blank = (hund == 4'd0);
      tens_blank = hund_blank && (tens == 4'd0);
      case (slot_q)
         2'd0:    slot_seg = digit_to_seg(units);
         2'd1:    slot_seg = tens_blank ? SEG_BLANK : digit_to_seg(tens);
         2'd2:    slot_seg = hund_blank ? SEG_BLANK : digit_to_seg(hund);
         default: slot_seg = SEG_UNIT;
      endcase
   end

   // Outputs refresh one cycle after the tick and hold until the next one, so
   // they stay dark after reset until the first slot is due.
   always_comb begin
      an_d  = an_q;
      seg_d = seg_q;
      dp_d  = 1'b1;
      if (upd_q) begin
         an_d  = ~(4'b0001 << slot_q);
         seg_d = slot_seg;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q    <= '0;
         idx_q    <= 2'd0;
         slot_q   <= 2'd0;
         upd_q    <= 1'b0;
         shadow_q <= 12'h000;
         disp_q   <= 12'h000;
         an_q     <= 4'b1111;
         seg_q    <= SEG_BLANK;
         dp_q     <= 1'b1;
      end else begin
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         slot_q   <= slot_d;
         upd_q    <= upd_d;
         shadow_q <= shadow_d;
         disp_q   <= disp_d;
         an_q     <= an_d;
         seg_q    <= seg_d;
         dp_q     <= dp_d;
      end
   end

   assign an  = an_q;
   assign seg = seg_q;
   assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver with a short refresh divider and a
// frame-level reference model (value shown in frame f = last load before edge f*FRAME).
module tb_seg7_scan_driver;

   localparam int DIV   = 4;
   localparam int FRAME = 4 * DIV;
   localparam int FIRST = DIV + 1;

   localparam logic [6:0] BLANK = 7'b1111111;
   localparam logic [6:0] DASH  = 7'b0111111;
`ifdef SEG7_UNIT_EN
   localparam logic [6:0] UNIT  = 7'b1000110;
`else
   localparam logic [6:0] UNIT  = 7'b1111111;
`endif
   localparam logic [6:0] DIGITS [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                          7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                          7'b0000000, 7'b0010000};
   localparam logic [3:0] AN_SLOT [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

   logic        clk  = 1'b0;
   logic        rst  = 1'b0;
   logic        load = 1'b0;
   logic [11:0] Y    = 12'h000;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;

   int          checks   = 0;
   int          failures = 0;
   int          edge_cnt = 0;
   logic [11:0] pending  = 12'h000;
   logic [11:0] frame_val [$];

   seg7_scan_driver #(.REFRESH_DIV(DIV)) dut (
      .clk (clk),
      .rst (rst),
      .Y   (Y),
      .load(load),
      .an  (an),
      .seg (seg),
      .dp  (dp)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] digit_seg(input int d);
      if (d > 9) return DASH;
      return DIGITS[d];
   endfunction

   function automatic logic [3:0] exp_an();
      int s;
      if (edge_cnt < FIRST) return 4'b1111;
      s = ((edge_cnt - FIRST) / DIV) % 4;
      return 4'(15 - (1 << s));
   endfunction

   function automatic logic [6:0] exp_seg();
      int rel, s, v, h, t, u;
      if (edge_cnt < FIRST) return BLANK;
      rel = edge_cnt - FIRST;
      s   = (rel / DIV) % 4;
      v   = int'(frame_val[rel / FRAME]);
      h   = (v / 256) % 16;
      t   = (v / 16) % 16;
      u   = v % 16;
      case (s)
         0:       return digit_seg(u);
         1:       return (h == 0 && t == 0) ? BLANK : digit_seg(t);
         2:       return (h == 0) ? BLANK : digit_seg(h);
         default: return UNIT;
      endcase
   endfunction

   function automatic int mid(input int f, input int s);
      return f * FRAME + s * DIV + FIRST + DIV / 2;
   endfunction

   function automatic logic [11:0] rand_value();
      int h, t, u;
      h = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(0, 15));
      t = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 15));
      u = int'($urandom_range(0, 15));
      return 12'(h * 256 + t * 16 + u);
   endfunction

   task automatic apply_reset();
      rst  = 1'b1;
      load = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst      = 1'b0;
      edge_cnt = 0;
      pending  = 12'h000;
      frame_val.delete();
      frame_val.push_back(12'h000);
   endtask

   task automatic tick1();
      logic        ld;
      logic [11:0] yv;
      ld = load;
      yv = Y;
      @(posedge clk);
      edge_cnt++;
      if (edge_cnt % FRAME == 0) frame_val.push_back(pending);
      if (ld) pending = yv;
      #1;
   endtask

   task automatic run_to(input int e);
      while (edge_cnt < e) tick1();
   endtask

   task automatic load_value(input logic [11:0] v, output int f);
      Y    = v;
      load = 1'b1;
      tick1();
      load = 1'b0;
      Y    = 12'($urandom);
      f    = edge_cnt / FRAME + 1;
   endtask

   task automatic test_reset();
      #2 rst = 1'b1;
      #1;
      checks++;
      if (an !== 4'b1111 || seg !== BLANK || dp !== 1'b1) begin
         failures++;
         $display("[TB] FAIL reset_async: got an=%b seg=%b dp=%b expected 1111 1111111 1", an, seg, dp);
      end
      apply_reset();
      for (int e = 1; e <= FIRST; e++) begin
         tick1();
         checks++;
         if (e < FIRST && (an !== 4'b1111 || seg !== BLANK || dp !== 1'b1)) begin
            failures++;
            $display("[TB] FAIL pre_tick edge %0d: got an=%b seg=%b dp=%b expected 1111 1111111 1", e, an, seg, dp);
         end else if (e == FIRST && (an !== 4'b1110 || seg !== DIGITS[0] || dp !== 1'b1)) begin
            failures++;
            $display("[TB] FAIL first_slot: got an=%b seg=%b dp=%b expected 1110 %b 1", an, seg, dp, DIGITS[0]);
         end
      end
   endtask

   task automatic test_display();
      logic [6:0] lit [4];
      int f;
      lit = '{7'b0010010, 7'b0110000, BLANK, UNIT};
      load_value(12'h035, f);
      for (int s = 0; s < 4; s++) begin
         run_to(mid(f, s));
         checks++;
         if (an !== AN_SLOT[s] || seg !== lit[s]) begin
            failures++;
            $display("[TB] FAIL display_035 slot %0d: got an=%b seg=%b expected %b %b", s, an, seg, AN_SLOT[s], lit[s]);
         end
      end
   endtask

   task automatic test_blanking();
      logic [11:0] vals [2];
      logic [6:0]  lit [2][4];
      int f;
      vals = '{12'h005, 12'h100};
      lit  = '{'{7'b0010010, BLANK, BLANK, UNIT},
               '{7'b1000000, 7'b1000000, 7'b1111001, UNIT}};
      for (int k = 0; k < 2; k++) begin
         load_value(vals[k], f);
         for (int s = 0; s < 4; s++) begin
            run_to(mid(f, s));
            checks++;
            if (an !== AN_SLOT[s] || seg !== lit[k][s]) begin
               failures++;
               $display("[TB] FAIL blanking_%h slot %0d: got an=%b seg=%b expected %b %b", vals[k], s, an, seg, AN_SLOT[s], lit[k][s]);
            end
         end
      end
   endtask

   task automatic test_invalid_digits();
      logic [11:0] vals [2];
      logic [6:0]  lit [2][4];
      int f;
      vals = '{12'h0A7, 12'hC05};
      lit  = '{'{7'b1111000, DASH, BLANK, UNIT},
               '{7'b0010010, 7'b1000000, DASH, UNIT}};
      for (int k = 0; k < 2; k++) begin
         load_value(vals[k], f);
         for (int s = 0; s < 4; s++) begin
            run_to(mid(f, s));
            checks++;
            if (an !== AN_SLOT[s] || seg !== lit[k][s]) begin
               failures++;
               $display("[TB] FAIL invalid_%h slot %0d: got an=%b seg=%b expected %b %b", vals[k], s, an, seg, AN_SLOT[s], lit[k][s]);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [6:0] old_lit [3];
      logic [6:0] new_lit [3];
      int f, g, dummy;
      // The frame in progress still shows 0xC05 from the previous scenario.
      old_lit = '{7'b0010010, 7'b1000000, DASH};
      new_lit = '{DIGITS[9], DIGITS[9], BLANK};
      f = edge_cnt / FRAME + 1;
      run_to(mid(f, 0));
      load_value(12'h012, dummy);
      run_to(mid(f, 1));
      load_value(12'h099, dummy);
      for (int s = 1; s < 3; s++) begin
         run_to(mid(f, s) + 1);
         checks++;
         if (seg !== old_lit[s]) begin
            failures++;
            $display("[TB] FAIL midframe_old slot %0d: got seg=%b expected %b", s, seg, old_lit[s]);
         end
      end
      for (int s = 0; s < 3; s++) begin
         run_to(mid(f + 1, s));
         checks++;
         if (seg !== new_lit[s]) begin
            failures++;
            $display("[TB] FAIL midframe_new slot %0d: got seg=%b expected %b", s, seg, new_lit[s]);
         end
      end
      g = edge_cnt / FRAME + 1;
      run_to(g * FRAME - 1);
      Y    = 12'h004;
      load = 1'b1;
      tick1();
      load = 1'b0;
      run_to(mid(g, 0));
      checks++;
      if (seg !== DIGITS[9]) begin
         failures++;
         $display("[TB] FAIL wrap_load_old: got seg=%b expected %b", seg, DIGITS[9]);
      end
      run_to(mid(g + 1, 0));
      checks++;
      if (seg !== 7'b0011001) begin
         failures++;
         $display("[TB] FAIL wrap_load_new_units: got seg=%b expected 0011001", seg);
      end
      run_to(mid(g + 1, 1));
      checks++;
      if (seg !== BLANK) begin
         failures++;
         $display("[TB] FAIL wrap_load_new_tens: got seg=%b expected 1111111", seg);
      end
   endtask

   task automatic test_reset_midframe();
      logic [6:0] lit [4];
      int f;
      lit = '{DIGITS[0], BLANK, BLANK, UNIT};
      f = edge_cnt / FRAME + 1;
      run_to(mid(f, 2));
      checks++;
      if (an !== 4'b1011) begin
         failures++;
         $display("[TB] FAIL pre_reset_slot2: got an=%b expected 1011", an);
      end
      #2 rst = 1'b1;
      #2;
      checks++;
      if (an !== 4'b1111 || seg !== BLANK || dp !== 1'b1) begin
         failures++;
         $display("[TB] FAIL midframe_reset_async: got an=%b seg=%b dp=%b expected 1111 1111111 1", an, seg, dp);
      end
      apply_reset();
      for (int e = 1; e < FIRST; e++) begin
         tick1();
         checks++;
         if (an !== 4'b1111 || seg !== BLANK) begin
            failures++;
            $display("[TB] FAIL post_reset_glitch edge %0d: got an=%b seg=%b expected 1111 1111111", e, an, seg);
         end
      end
      for (int s = 0; s < 4; s++) begin
         run_to(mid(0, s));
         checks++;
         if (an !== AN_SLOT[s] || seg !== lit[s]) begin
            failures++;
            $display("[TB] FAIL restart slot %0d: got an=%b seg=%b expected %b %b", s, an, seg, AN_SLOT[s], lit[s]);
         end
      end
   endtask

   task automatic test_random();
      logic [3:0] ea;
      logic [6:0] es;
      for (int n = 0; n < 30 * FRAME; n++) begin
         load = ($urandom_range(0, 7) == 0);
         Y    = rand_value();
         tick1();
         ea = exp_an();
         es = exp_seg();
         checks++;
         if (an !== ea || seg !== es || dp !== 1'b1) begin
            failures++;
            $display("[TB] FAIL random edge %0d: got an=%b seg=%b dp=%b expected %b %b 1", edge_cnt, an, seg, dp, ea, es);
         end
      end
      load = 1'b0;
   endtask

   initial begin
      test_reset();
      test_display();
      test_blanking();
      test_invalid_digits();
      test_back_to_back();
      test_reset_midframe();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
